// File: rtl/t_mem_loader.sv
// Streams bytes into a word-addressed single-port RAM, packing them little-endian
// into DATA_WIDTH words written at consecutive (wrapping) addresses from a base.
module t_mem_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  abort,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_wren,
   output logic                  busy,
   output logic                  done
);

   localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BYTES_PER_WORD - 1);
   localparam logic [BCW-1:0]      BYTE_ONE  = BCW'(1);
   localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
   logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      byte_cnt_d  = byte_cnt_q;
      data_d      = data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (word_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  addr_d      = base_addr;
                  remaining_d = word_count;
                  byte_cnt_d  = '0;
                  state_d     = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            // abort takes priority over a byte arriving in the same cycle; the partial word is dropped
            if (abort) begin
               state_d = S_IDLE;
            end else if (in_valid) begin
               data_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
               byte_cnt_d = byte_cnt_q + BYTE_ONE;
               if (byte_cnt_q == LAST_BYTE) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               addr_d      = addr_q + ADDR_ONE;
               remaining_d = remaining_q - ONE_WORD;
               if (remaining_q == ONE_WORD) begin
                  state_d = S_DONE;
               end else begin
                  byte_cnt_d = '0;
                  state_d    = S_COLLECT;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         byte_cnt_q  <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         byte_cnt_q  <= byte_cnt_d;
         data_q      <= data_d;
      end
   end

   // Every output comes straight from a register so the RAM port sees no input-to-output paths.
   assign in_ready    = (state_q == S_COLLECT);
   assign mem_wren    = (state_q == S_WRITE);
   assign busy        = (state_q == S_COLLECT) || (state_q == S_WRITE);
   assign done        = (state_q == S_DONE);
   assign mem_address = addr_q;
   assign mem_data    = data_q;

endmodule

// File: tb/tb_t_mem_loader.sv
// Self-checking bench for t_mem_loader: directed scenarios plus randomized loads
// compared against a byte-stream-to-word reference model.
module tb_t_mem_loader;

   localparam int AW = 7;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   word_count;
   logic          abort;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data;
   logic          mem_wren;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;

   int cycle_cnt = 0;
   int done_cnt;
   int done_cyc;
   int last_wren_cyc;
   int start_cyc;
   int ready_in_write;
   bit busy_seen;

   logic [7:0]    stim_bytes[$];
   logic [AW-1:0] obs_addr[$];
   logic [AW-1:0] exp_addr[$];
   logic [DW-1:0] obs_data[$];
   logic [DW-1:0] exp_data[$];

   t_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .word_count(word_count), .abort(abort), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_address(mem_address), .mem_data(mem_data),
      .mem_wren(mem_wren), .busy(busy), .done(done)
   );

   // Free-running clock and a cycle counter used for latency measurements
   always #5 clock = ~clock;
   always @(posedge clock) cycle_cnt++;

   // Monitor samples on the falling edge, half a cycle away from DUT updates
   always @(negedge clock) begin
      if (mem_wren) begin
         obs_addr.push_back(mem_address);
         obs_data.push_back(mem_data);
         last_wren_cyc = cycle_cnt;
         if (in_ready) ready_in_write++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cycle_cnt;
      end
      if (busy) busy_seen = 1'b1;
   end

   task automatic clear_monitor();
      obs_addr.delete();
      obs_data.delete();
      done_cnt = 0;
      done_cyc = -1;
      last_wren_cyc = -1;
      ready_in_write = 0;
      busy_seen = 1'b0;
   endtask

   task automatic fill_random(input int n);
      stim_bytes.delete();
      for (int i = 0; i < n; i++) stim_bytes.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic fill_ramp(input int n);
      stim_bytes.delete();
      for (int i = 0; i < n; i++) stim_bytes.push_back(8'(i % 256));
   endtask

   // Reference model: word k is bytes 4k..4k+3 weighted by powers of 256, stored at (base+k) mod 128
   task automatic build_expected(input int base, input int cnt);
      longint w;
      exp_addr.delete();
      exp_data.delete();
      for (int k = 0; k < cnt; k++) begin
         w = 0;
         for (int b = 3; b >= 0; b--) w = w * 256 + longint'(stim_bytes[4*k+b]);
         exp_addr.push_back(AW'((base + k) % 128));
         exp_data.push_back(DW'(w));
      end
   endtask

   // Called and returns on a falling edge; start is seen by the DUT on the rising edge in between
   task automatic do_start(input int base, input int cnt);
      base_addr  = AW'(base);
      word_count = (AW+1)'(cnt);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      start_cyc = cycle_cnt;
   endtask

   // mode 0: back-to-back, 1: valid one cycle in three, 2: random ~60% valid
   task automatic drive_stream(input int n, input int mode, input bit mid_start, output bit ok);
      int idx = 0;
      int iter = 0;
      bit v;
      bit acc;
      while (idx < n && iter < n * 10 + 100) begin
         case (mode)
            0: v = 1'b1;
            1: v = (iter % 3 == 0);
            default: v = ($urandom_range(0, 99) < 60);
         endcase
         in_valid = v;
         in_data  = v ? stim_bytes[idx] : 8'h00;
         start    = mid_start && (iter == 600);
         acc      = v && in_ready;
         @(negedge clock);
         if (acc) idx++;
         iter++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      ok = (idx == n);
   endtask

   task automatic wait_done(input int bound, output bit found);
      found = 1'b0;
      for (int i = 0; i < bound && !found; i++) begin
         @(negedge clock);
         if (done) found = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      base_addr = '0; word_count = '0;
      repeat (3) @(negedge clock);
      n_checks++;
      if ({in_ready, mem_wren, busy, done} !== 4'b0000) begin
         n_errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 0000", {in_ready, mem_wren, busy, done});
      end
      n_checks++;
      if ({mem_address, mem_data} !== '0) begin
         n_errors++;
         $display("[TB] FAIL reset_bus: got addr %h data %h expected 0", mem_address, mem_data);
      end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_single_word();
      bit ok, found;
      clear_monitor();
      stim_bytes.delete();
      stim_bytes.push_back(8'h11); stim_bytes.push_back(8'h22);
      stim_bytes.push_back(8'h33); stim_bytes.push_back(8'h44);
      do_start(0, 1);
      drive_stream(4, 0, 1'b0, ok);
      wait_done(20, found);
      n_checks++;
      if (!(ok && found)) begin
         n_errors++;
         $display("[TB] FAIL single_timeout: got ok=%0d done=%0d expected 1/1", ok, found);
      end
      n_checks++;
      if (obs_addr.size() !== 1) begin
         n_errors++;
         $display("[TB] FAIL single_writes: got %0d expected 1", obs_addr.size());
      end else begin
         n_checks++;
         if (obs_addr[0] !== 7'd0 || obs_data[0] !== 32'h44332211) begin
            n_errors++;
            $display("[TB] FAIL single_word: got %h@%h expected 44332211@00", obs_data[0], obs_addr[0]);
         end
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc !== last_wren_cyc + 1) begin
         n_errors++;
         $display("[TB] FAIL single_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_cyc, last_wren_cyc + 1);
      end
   endtask

   task automatic test_full_load();
      bit ok, found;
      clear_monitor();
      fill_ramp(512);
      build_expected(0, 128);
      do_start(0, 128);
      drive_stream(512, 0, 1'b0, ok);
      wait_done(50, found);
      n_checks++;
      if (!(ok && found)) begin
         n_errors++;
         $display("[TB] FAIL full_timeout: got ok=%0d done=%0d expected 1/1", ok, found);
      end
      n_checks++;
      if (obs_addr.size() !== 128) begin
         n_errors++;
         $display("[TB] FAIL full_writes: got %0d expected 128", obs_addr.size());
      end
      for (int k = 0; k < 128 && k < obs_addr.size(); k++) begin
         n_checks++;
         if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin
            n_errors++;
            $display("[TB] FAIL full_word%0d: got %h@%h expected %h@%h", k, obs_data[k], obs_addr[k], exp_data[k], exp_addr[k]);
         end
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc - start_cyc !== 640) begin
         n_errors++;
         $display("[TB] FAIL full_latency: got %0d pulses, %0d cycles expected 1, 640", done_cnt, done_cyc - start_cyc);
      end
      n_checks++;
      if (mem_address !== 7'd0) begin
         n_errors++;
         $display("[TB] FAIL full_end_addr: got %h expected 00", mem_address);
      end
   endtask

   task automatic test_addr_wrap();
      bit ok, found;
      clear_monitor();
      fill_random(16);
      build_expected(126, 4);
      do_start(126, 4);
      drive_stream(16, 0, 1'b0, ok);
      wait_done(20, found);
      n_checks++;
      if (!(ok && found) || obs_addr.size() !== 4) begin
         n_errors++;
         $display("[TB] FAIL wrap_writes: got %0d writes ok=%0d done=%0d expected 4", obs_addr.size(), ok, found);
      end
      for (int k = 0; k < 4 && k < obs_addr.size(); k++) begin
         n_checks++;
         if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin
            n_errors++;
            $display("[TB] FAIL wrap_word%0d: got %h@%h expected %h@%h", k, obs_data[k], obs_addr[k], exp_data[k], exp_addr[k]);
         end
      end
      if (obs_addr.size() > 0) begin
         n_checks++;
         if (obs_addr[obs_addr.size()-1] !== 7'd1) begin
            n_errors++;
            $display("[TB] FAIL wrap_last_addr: got %h expected 01", obs_addr[obs_addr.size()-1]);
         end
      end
   endtask

   task automatic test_gapped();
      bit ok, found;
      clear_monitor();
      fill_ramp(512);
      build_expected(0, 128);
      do_start(0, 128);
      base_addr  = 7'd50;
      word_count = 8'd3;
      drive_stream(512, 1, 1'b1, ok);
      wait_done(50, found);
      n_checks++;
      if (!(ok && found) || obs_addr.size() !== 128) begin
         n_errors++;
         $display("[TB] FAIL gap_writes: got %0d writes ok=%0d done=%0d expected 128", obs_addr.size(), ok, found);
      end
      for (int k = 0; k < 128 && k < obs_addr.size(); k++) begin
         n_checks++;
         if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin
            n_errors++;
            $display("[TB] FAIL gap_word%0d: got %h@%h expected %h@%h", k, obs_data[k], obs_addr[k], exp_data[k], exp_addr[k]);
         end
      end
      n_checks++;
      if (ready_in_write !== 0 || done_cnt !== 1) begin
         n_errors++;
         $display("[TB] FAIL gap_ready_done: got ready_in_write=%0d done=%0d expected 0, 1", ready_in_write, done_cnt);
      end
   endtask

   task automatic test_zero_count();
      clear_monitor();
      do_start(33, 0);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL zero_done_now: got done=%b busy=%b expected 1, 0", done, busy);
      end
      repeat (5) @(negedge clock);
      n_checks++;
      if (obs_addr.size() !== 0 || busy_seen !== 1'b0 || done_cnt !== 1 || done_cyc !== start_cyc) begin
         n_errors++;
         $display("[TB] FAIL zero_count: got writes=%0d busy_seen=%0d done=%0d at %0d expected 0,0,1 at %0d",
                  obs_addr.size(), busy_seen, done_cnt, done_cyc, start_cyc);
      end
   endtask

   task automatic test_abort_reset();
      bit ok, found;
      clear_monitor();
      fill_random(8);
      do_start(10, 2);
      drive_stream(2, 0, 1'b0, ok);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      repeat (4) @(negedge clock);
      n_checks++;
      if (!ok || busy !== 1'b0 || in_ready !== 1'b0 || obs_addr.size() !== 0 || done_cnt !== 0) begin
         n_errors++;
         $display("[TB] FAIL abort: got ok=%0d busy=%b ready=%b writes=%0d done=%0d expected 1,0,0,0,0",
                  ok, busy, in_ready, obs_addr.size(), done_cnt);
      end

      clear_monitor();
      stim_bytes.delete();
      stim_bytes.push_back(8'hA5); stim_bytes.push_back(8'h5A); stim_bytes.push_back(8'hC3);
      do_start(20, 1);
      drive_stream(2, 0, 1'b0, ok);
      in_valid = 1'b1;
      in_data  = stim_bytes[2];
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, mem_wren, busy, done} !== 4'b0000 || {mem_address, mem_data} !== '0) begin
         n_errors++;
         $display("[TB] FAIL async_reset: got ctrl=%b addr=%h data=%h expected all 0",
                  {in_ready, mem_wren, busy, done}, mem_address, mem_data);
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (obs_addr.size() !== 0 || done_cnt !== 0) begin
         n_errors++;
         $display("[TB] FAIL reset_no_write: got writes=%0d done=%0d expected 0, 0", obs_addr.size(), done_cnt);
      end
      reset_n = 1'b1;
      @(negedge clock);

      clear_monitor();
      stim_bytes.delete();
      stim_bytes.push_back(8'hEF); stim_bytes.push_back(8'hBE);
      stim_bytes.push_back(8'hAD); stim_bytes.push_back(8'hDE);
      do_start(5, 1);
      drive_stream(4, 0, 1'b0, ok);
      wait_done(20, found);
      n_checks++;
      if (!(ok && found) || obs_addr.size() !== 1) begin
         n_errors++;
         $display("[TB] FAIL post_reset_writes: got %0d ok=%0d done=%0d expected 1", obs_addr.size(), ok, found);
      end else begin
         n_checks++;
         if (obs_data[0] !== 32'hDEADBEEF || obs_addr[0] !== 7'd5) begin
            n_errors++;
            $display("[TB] FAIL post_reset_word: got %h@%h expected deadbeef@05", obs_data[0], obs_addr[0]);
         end
      end
   endtask

   task automatic test_random_loads();
      bit ok, found;
      int base, cnt;
      for (int t = 0; t < 6; t++) begin
         base = $urandom_range(0, 127);
         cnt  = $urandom_range(1, 6);
         clear_monitor();
         fill_random(4 * cnt);
         build_expected(base, cnt);
         do_start(base, cnt);
         drive_stream(4 * cnt, 2, 1'b0, ok);
         wait_done(20, found);
         n_checks++;
         if (!(ok && found) || obs_addr.size() !== cnt || done_cnt !== 1) begin
            n_errors++;
            $display("[TB] FAIL rand%0d_count: got %0d writes %0d done ok=%0d expected %0d, 1", t, obs_addr.size(), done_cnt, ok, cnt);
         end
         for (int k = 0; k < cnt && k < obs_addr.size(); k++) begin
            n_checks++;
            if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin
               n_errors++;
               $display("[TB] FAIL rand%0d_word%0d: got %h@%h expected %h@%h", t, k, obs_data[k], obs_addr[k], exp_data[k], exp_addr[k]);
            end
         end
         n_checks++;
         if (mem_address !== AW'((base + cnt) % 128)) begin
            n_errors++;
            $display("[TB] FAIL rand%0d_end_addr: got %h expected %h", t, mem_address, AW'((base + cnt) % 128));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_full_load();
      test_addr_wrap();
      test_gapped();
      test_zero_count();
      test_abort_reset();
      test_random_loads();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
